// File: rtl/multi_change_checker.sv
// Debounces CHANNELS independent buses, flags each accepted change and queues the
// accepted values as events drained round-robin over a valid/ready port.
module multi_change_checker #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned WIDTH        = 3,
    parameter int unsigned PERIOD_COUNT = 5,
    parameter int unsigned MODE         = 0
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [CHANNELS*WIDTH-1:0]                        the_signal,
    output logic [CHANNELS-1:0]                              change,
    output logic [CHANNELS*WIDTH-1:0]                        stable_value,
    output logic                                             evt_valid,
    input  logic                                             evt_ready,
    output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] evt_channel,
    output logic [WIDTH-1:0]                                 evt_value,
    output logic [CHANNELS-1:0]                              overrun
);
    localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CntW = (PERIOD_COUNT > 1) ? $clog2(PERIOD_COUNT) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(PERIOD_COUNT - 1);
    localparam logic [ChW-1:0]  PtrInit = ChW'(CHANNELS - 1);

    logic [CHANNELS-1:0][WIDTH-1:0] w_in;
    logic [CHANNELS-1:0][WIDTH-1:0] r_sample, w_sample_d;
    logic [CHANNELS-1:0][WIDTH-1:0] r_stable, w_stable_d;
    logic [CHANNELS-1:0][WIDTH-1:0] r_ev_val, w_ev_val_d;
    logic [CHANNELS-1:0][CntW-1:0]  r_cnt, w_cnt_d;
    logic [CHANNELS-1:0]            w_accept, w_consumed, w_cand;
    logic [CHANNELS-1:0]            r_change, w_change_d;
    logic [CHANNELS-1:0]            r_pending, w_pending_d;
    logic [CHANNELS-1:0]            r_overrun, w_overrun_d;
    logic                           w_hs, w_load, w_found;
    logic                           r_reacc, w_reacc_d;
    logic                           r_evt_valid, w_evt_valid_d;
    logic [ChW-1:0]                 w_sel, w_idx;
    logic [ChW-1:0]                 r_ptr, w_ptr_d;
    logic [ChW-1:0]                 r_evt_channel, w_evt_channel_d;
    logic [WIDTH-1:0]               r_evt_value, w_evt_value_d;

    assign w_in = the_signal;

    always_comb begin
        w_sample_d = r_sample;
        w_cnt_d    = r_cnt;
        w_stable_d = r_stable;
        w_accept   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_in[i] != r_sample[i]) begin
                w_sample_d[i] = w_in[i];
                w_cnt_d[i]    = '0;
            end else if (r_sample[i] == r_stable[i]) begin
                w_cnt_d[i] = '0;
            end else if (r_cnt[i] == CntMax) begin
                w_accept[i]   = 1'b1;
                w_stable_d[i] = r_sample[i];
                w_cnt_d[i]    = '0;
            end else begin
                w_cnt_d[i] = r_cnt[i] + 1'b1;
            end
        end
        if (MODE == 0) begin
            w_change_d = w_accept;
        end else begin
            w_change_d = r_change ^ w_accept;
        end
    end

    // r_reacc marks that the presented channel accepted again after being loaded, so its
    // pending entry now holds a newer value that the handshake must not discard.
    always_comb begin
        w_hs   = r_evt_valid & evt_ready;
        w_load = ~r_evt_valid | evt_ready;
        for (int i = 0; i < CHANNELS; i++) begin
            w_consumed[i] = w_hs && (r_evt_channel == ChW'(i)) && !r_reacc;
        end
        w_cand  = r_pending & ~w_consumed;
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = '0;
        for (int j = 1; j <= CHANNELS; j++) begin
            w_idx = ChW'((int'(r_ptr) + j) % CHANNELS);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_pending_d = r_pending;
        w_ev_val_d  = r_ev_val;
        w_overrun_d = r_overrun;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_accept[i]) begin
                w_pending_d[i] = 1'b1;
                w_ev_val_d[i]  = r_sample[i];
                if (r_pending[i] && !w_consumed[i]) begin
                    w_overrun_d[i] = 1'b1;
                end
            end else if (w_consumed[i]) begin
                w_pending_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_evt_valid_d   = r_evt_valid;
        w_evt_channel_d = r_evt_channel;
        w_evt_value_d   = r_evt_value;
        w_ptr_d         = r_ptr;
        w_reacc_d       = r_reacc | (r_evt_valid & w_accept[r_evt_channel]);
        if (w_load) begin
            w_evt_valid_d = w_found;
            w_reacc_d     = 1'b0;
            if (w_found) begin
                w_evt_channel_d = w_sel;
                w_evt_value_d   = r_ev_val[w_sel];
                w_ptr_d         = w_sel;
                w_reacc_d       = w_accept[w_sel];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sample      <= '0;
            r_cnt         <= '0;
            r_stable      <= '0;
            r_change      <= '0;
            r_pending     <= '0;
            r_ev_val      <= '0;
            r_overrun     <= '0;
            r_reacc       <= 1'b0;
            r_evt_valid   <= 1'b0;
            r_evt_channel <= '0;
            r_evt_value   <= '0;
            r_ptr         <= PtrInit;
        end else begin
            r_sample      <= w_sample_d;
            r_cnt         <= w_cnt_d;
            r_stable      <= w_stable_d;
            r_change      <= w_change_d;
            r_pending     <= w_pending_d;
            r_ev_val      <= w_ev_val_d;
            r_overrun     <= w_overrun_d;
            r_reacc       <= w_reacc_d;
            r_evt_valid   <= w_evt_valid_d;
            r_evt_channel <= w_evt_channel_d;
            r_evt_value   <= w_evt_value_d;
            r_ptr         <= w_ptr_d;
        end
    end

    assign change       = r_change;
    assign stable_value = r_stable;
    assign evt_valid    = r_evt_valid;
    assign evt_channel  = r_evt_channel;
    assign evt_value    = r_evt_value;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_multi_change_checker.sv
// Bench for multi_change_checker: directed scenarios plus randomized traffic on two
// configurations (PERIOD_COUNT=5/MODE 0 and PERIOD_COUNT=1/MODE 1) against a reference model.
module tb_multi_change_checker;
    localparam int CH = 4;
    localparam int W  = 3;

    logic            clk;
    logic            reset;
    logic            evt_ready;
    logic [CH*W-1:0] the_signal;
    logic [CH-1:0]   change0, ovr0, change1, ovr1;
    logic [CH*W-1:0] stable0, stable1;
    logic            ev0, ev1;
    logic [1:0]      ech0, ech1;
    logic [W-1:0]    eval0, eval1;

    int n_tests = 0;
    int n_fail  = 0;

    multi_change_checker #(.CHANNELS(CH), .WIDTH(W), .PERIOD_COUNT(5), .MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .the_signal(the_signal), .change(change0),
        .stable_value(stable0), .evt_valid(ev0), .evt_ready(evt_ready),
        .evt_channel(ech0), .evt_value(eval0), .overrun(ovr0)
    );

    multi_change_checker #(.CHANNELS(CH), .WIDTH(W), .PERIOD_COUNT(1), .MODE(1)) u_dut1 (
        .clk(clk), .reset(reset), .the_signal(the_signal), .change(change1),
        .stable_value(stable1), .evt_valid(ev1), .evt_ready(evt_ready),
        .evt_channel(ech1), .evt_value(eval1), .overrun(ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, index [d] = 0 for u_dut0, 1 for u_dut1.
    int           m_run[2][CH];
    logic [W-1:0] m_last[2][CH];
    logic [W-1:0] m_stable[2][CH];
    logic [W-1:0] m_slot[2][CH];
    bit           m_change[2][CH];
    bit           m_pend[2][CH];
    bit           m_infl[2][CH];
    bit           m_ovr[2][CH];
    bit           m_pv[2];
    int           m_pch[2];
    logic [W-1:0] m_pval[2];
    int           m_ptr[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                m_run[d][c] = 1;
                m_last[d][c] = '0;
                m_stable[d][c] = '0;
                m_slot[d][c] = '0;
                m_change[d][c] = 1'b0;
                m_pend[d][c] = 1'b0;
                m_infl[d][c] = 1'b0;
                m_ovr[d][c] = 1'b0;
            end
            m_pv[d] = 1'b0;
            m_pch[d] = 0;
            m_pval[d] = '0;
            m_ptr[d] = CH - 1;
        end
    endtask

    // A value is accepted once it has been seen on PERIOD_COUNT+1 consecutive edges
    // and differs from the last accepted value.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int           pc;
            int           sel;
            int           idx;
            bit           acc[CH];
            bit           cons[CH];
            logic [W-1:0] inv[CH];
            bit           hs, load, found;
            logic [W-1:0] oldslot;
            pc = (d == 0) ? 5 : 1;
            hs = m_pv[d] && evt_ready;
            load = !m_pv[d] || evt_ready;
            for (int c = 0; c < CH; c++) begin
                inv[c] = the_signal[c*W +: W];
                if (inv[c] == m_last[d][c]) begin
                    if (m_run[d][c] < 1000) m_run[d][c]++;
                end else begin
                    m_run[d][c] = 1;
                end
                m_last[d][c] = inv[c];
                acc[c] = (m_run[d][c] >= pc + 1) && (inv[c] != m_stable[d][c]);
                cons[c] = hs && (m_pch[d] == c) && m_infl[d][c];
            end
            found = 1'b0;
            sel = 0;
            for (int j = 1; j <= CH; j++) begin
                idx = (m_ptr[d] + j) % CH;
                if (!found && m_pend[d][idx] && !cons[idx]) begin
                    found = 1'b1;
                    sel = idx;
                end
            end
            oldslot = m_slot[d][sel];
            for (int c = 0; c < CH; c++) begin
                if (acc[c]) begin
                    if (m_pend[d][c] && !cons[c]) m_ovr[d][c] = 1'b1;
                    m_pend[d][c] = 1'b1;
                    m_slot[d][c] = inv[c];
                    m_stable[d][c] = inv[c];
                end else if (cons[c]) begin
                    m_pend[d][c] = 1'b0;
                end
                m_change[d][c] = (d == 0) ? acc[c] : (m_change[d][c] ^ acc[c]);
            end
            if (load) begin
                for (int c = 0; c < CH; c++) m_infl[d][c] = 1'b0;
                m_pv[d] = found;
                if (found) begin
                    m_pch[d] = sel;
                    m_pval[d] = oldslot;
                    m_ptr[d] = sel;
                    m_infl[d][sel] = !acc[sel];
                end
            end else if (acc[m_pch[d]]) begin
                m_infl[d][m_pch[d]] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        the_signal = '0;
        evt_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        the_signal = '0;
        evt_ready = 1'b0;
        #1;
        n_tests++;
        if ({change0, stable0, ev0, ech0, eval0, ovr0} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut0 got %h want 0", {change0, stable0, ev0, ech0, eval0, ovr0});
        end
        n_tests++;
        if ({change1, stable1, ev1, ech1, eval1, ovr1} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut1 got %h want 0", {change1, stable1, ev1, ech1, eval1, ovr1});
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        the_signal = 12'h001;
        for (int j = 0; j <= 6; j++) begin
            tick();
            n_tests++;
            if (change0[0] !== (j == 5)) begin
                n_fail++;
                $display("FAIL single_change edge k+%0d got %b want %b", j, change0[0], j == 5);
            end
            n_tests++;
            if (ev0 !== (j >= 6)) begin
                n_fail++;
                $display("FAIL single_valid edge k+%0d got %b want %b", j, ev0, j >= 6);
            end
        end
        n_tests++;
        if ({ech0, eval0, stable0[2:0]} !== {2'd0, 3'd1, 3'd1}) begin
            n_fail++;
            $display("FAIL single_event got ch%0d val%0d stable%0d want ch0 val1 stable1",
                     ech0, eval0, stable0[2:0]);
        end
        evt_ready = 1'b1;
        tick();
        n_tests++;
        if (ev0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_consume got valid %b want 0", ev0);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_glitch();
        apply_reset();
        the_signal = 12'h018;
        for (int j = 0; j < 11; j++) begin
            if (j == 3) the_signal = '0;
            tick();
            n_tests++;
            if ({change0, ev0} !== 5'b0) begin
                n_fail++;
                $display("FAIL glitch cycle %0d got change %b valid %b want 0", j, change0, ev0);
            end
        end
        n_tests++;
        if (stable0[5:3] !== 3'd0) begin
            n_fail++;
            $display("FAIL glitch_stable got %0d want 0", stable0[5:3]);
        end
    endtask

    task automatic test_simultaneous();
        int           exp_ch[3];
        logic [W-1:0] exp_val[3];
        exp_ch = '{0, 2, 3};
        exp_val = '{3'd5, 3'd6, 3'd7};
        apply_reset();
        evt_ready = 1'b1;
        the_signal = {3'd7, 3'd6, 3'd0, 3'd5};
        repeat (6) tick();
        n_tests++;
        if (change0 !== 4'b1101) begin
            n_fail++;
            $display("FAIL simul_change got %b want 1101", change0);
        end
        for (int e = 0; e < 3; e++) begin
            tick();
            n_tests++;
            if ({ev0, ech0, eval0} !== {1'b1, 2'(exp_ch[e]), exp_val[e]}) begin
                n_fail++;
                $display("FAIL simul_event %0d got v%b ch%0d val%0d want v1 ch%0d val%0d",
                         e, ev0, ech0, eval0, exp_ch[e], exp_val[e]);
            end
        end
        tick();
        n_tests++;
        if (ev0 !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_drained got valid %b want 0", ev0);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_overrun();
        apply_reset();
        the_signal = 12'h040;
        repeat (7) tick();
        n_tests++;
        if ({ev0, ech0, eval0, ovr0} !== {1'b1, 2'd2, 3'd1, 4'b0000}) begin
            n_fail++;
            $display("FAIL overrun_first got v%b ch%0d val%0d ovr%b want v1 ch2 val1 ovr0000",
                     ev0, ech0, eval0, ovr0);
        end
        the_signal = 12'h080;
        repeat (6) tick();
        n_tests++;
        if ({ev0, ech0, eval0, ovr0, stable0[8:6]} !== {1'b1, 2'd2, 3'd1, 4'b0100, 3'd2}) begin
            n_fail++;
            $display("FAIL overrun_hold got v%b ch%0d val%0d ovr%b st%0d want v1 ch2 val1 0100 2",
                     ev0, ech0, eval0, ovr0, stable0[8:6]);
        end
        evt_ready = 1'b1;
        tick();
        n_tests++;
        if ({ev0, ech0, eval0} !== {1'b1, 2'd2, 3'd2}) begin
            n_fail++;
            $display("FAIL overrun_second got v%b ch%0d val%0d want v1 ch2 val2", ev0, ech0, eval0);
        end
        tick();
        n_tests++;
        if ({ev0, ovr0} !== {1'b0, 4'b0100}) begin
            n_fail++;
            $display("FAIL overrun_end got v%b ovr%b want v0 ovr0100", ev0, ovr0);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_mode1();
        bit exp_chg[6];
        exp_chg = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int j = 0; j < 6; j++) begin
            the_signal = 12'(j / 2 + 1);
            tick();
            n_tests++;
            if (change1[0] !== exp_chg[j]) begin
                n_fail++;
                $display("FAIL mode1_toggle step %0d got %b want %b", j, change1[0], exp_chg[j]);
            end
        end
        n_tests++;
        if (stable1[2:0] !== 3'd3) begin
            n_fail++;
            $display("FAIL mode1_stable got %0d want 3", stable1[2:0]);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        the_signal = 12'h020;
        repeat (7) tick();
        the_signal = 12'h022;
        repeat (4) tick();
        n_tests++;
        if (ev0 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre got valid %b want 1", ev0);
        end
        reset = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({change0, stable0, ev0, ech0, eval0, ovr0} !== '0) begin
            n_fail++;
            $display("FAIL midreset_async got %h want 0", {change0, stable0, ev0, ech0, eval0, ovr0});
        end
        the_signal = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            n_tests++;
            if ({change0, ev0} !== 5'b0) begin
                n_fail++;
                $display("FAIL midreset_after cycle %0d got change %b valid %b want 0",
                         j, change0, ev0);
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0]   e_change, e_ovr, g_change, g_ovr;
        logic [CH*W-1:0] e_stable, g_stable;
        logic            g_v;
        logic [1:0]      g_ch;
        logic [W-1:0]    g_val;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) the_signal[c*W +: W] = 3'($urandom);
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            tick();
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < CH; c++) begin
                    e_change[c] = m_change[d][c];
                    e_ovr[c] = m_ovr[d][c];
                    e_stable[c*W +: W] = m_stable[d][c];
                end
                g_change = (d == 0) ? change0 : change1;
                g_ovr = (d == 0) ? ovr0 : ovr1;
                g_stable = (d == 0) ? stable0 : stable1;
                g_v = (d == 0) ? ev0 : ev1;
                g_ch = (d == 0) ? ech0 : ech1;
                g_val = (d == 0) ? eval0 : eval1;
                n_tests++;
                if ({g_change, g_ovr, g_stable} !== {e_change, e_ovr, e_stable}) begin
                    n_fail++;
                    $display("FAIL rand_state d%0d cyc%0d got chg%b ovr%b st%h want chg%b ovr%b st%h",
                             d, cyc, g_change, g_ovr, g_stable, e_change, e_ovr, e_stable);
                end
                n_tests++;
                if ({g_v, g_ch, g_val} !== {m_pv[d], 2'(m_pch[d]), m_pval[d]}) begin
                    n_fail++;
                    $display("FAIL rand_event d%0d cyc%0d got v%b ch%0d val%0d want v%b ch%0d val%0d",
                             d, cyc, g_v, g_ch, g_val, m_pv[d], m_pch[d], m_pval[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_simultaneous();
        test_overrun();
        test_mode1();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_change_checker.md
Name: multi_change_checker

Overview:
- Multi-channel successor to the single-signal change checker.
- Watches CHANNELS independent WIDTH-bit buses and accepts a new value only after it has been held stable for PERIOD_COUNT clocks, which filters glitches.
- Flags each accepted change on a per-channel output (pulse or toggle, set by MODE).
- Queues accepted changes as events and presents them one at a time on a round-robin valid/ready port. This feeds the LCD controller's refresh logic.

Parameters:
- CHANNELS, 4, number of monitored buses (>=1).
- WIDTH, 3, bits per bus (>=1).
- PERIOD_COUNT, 5, consecutive equal samples required before acceptance (>=1).
- MODE, 0, 0 = change is a one-cycle pulse per acceptance; 1 = change bit toggles per acceptance.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- the_signal  in  CHANNELS*WIDTH  monitored buses; channel i = bits [i*WIDTH +: WIDTH].
- change  out  CHANNELS  per-channel acceptance indication (per MODE).
- stable_value  out  CHANNELS*WIDTH  last accepted value per channel.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_channel  out  max(1,$clog2(CHANNELS))  channel index of presented event.
- evt_value  out  WIDTH  accepted value of presented event.
- overrun  out  CHANNELS  sticky: an event was overwritten before it was consumed.

Behaviour:
- Reset (reset=0, async): all sample registers, counters, stable_value, change, pending, stored event values, evt_valid, evt_channel, evt_value and overrun go to 0. The round-robin pointer is set so channel 0 has first priority.
- Per-channel filter, every edge:
  - If input != sample_q: sample_q <= input, cnt <= 0.
  - Else if sample_q == stable: cnt <= 0.
  - Else if cnt == PERIOD_COUNT-1: ACCEPT (stable <= sample_q, cnt <= 0).
  - Else: cnt <= cnt+1.
- Acceptance latency:
  - Value V first sampled at edge k is accepted at edge k+PERIOD_COUNT.
  - stable_value and change update at that edge.
  - PERIOD_COUNT=1 gives acceptance at edge k+1.
- Glitch: if the input returns to the stable value before acceptance, no acceptance and change stays 0. A different new value restarts the count.
- change: in MODE 0, high exactly one cycle after each ACCEPT edge. In MODE 1, the bit inverts at each ACCEPT edge.
- Event store, per channel:
  - ACCEPT sets pending[i] and latches ev_val[i] <= accepted value.
  - If pending[i] was already set and is not being cleared by a handshake that same edge: ev_val[i] is overwritten and overrun[i] <= 1.
  - overrun clears only on reset.
- Presentation:
  - evt_valid, evt_channel and evt_value are registered.
  - When evt_valid=0, or evt_valid&evt_ready at this edge, the block loads the next event: the first pending channel searched from pointer+1 upward with wrap, using pending state as of before this edge.
  - On load: evt_valid <= 1, evt_channel/evt_value <= that channel and its ev_val, and pointer <= that channel. If none is pending, evt_valid <= 0.
  - Earliest evt_valid is one edge after ACCEPT.
- Handshake: evt_valid & evt_ready clears pending[evt_channel], unless the same channel ACCEPTs on that edge; then pending stays set with the new value and no overrun is flagged.
- Hold: while evt_valid=1 and evt_ready=0, evt_channel and evt_value stay constant, even if that channel ACCEPTs again (its ev_val and overrun update; the presented value does not).
- Throughput: one event per cycle when evt_ready is held high.
- Simultaneous ACCEPTs on several channels are all captured in the same edge, then drained in round-robin order.
- Reset mid-count or mid-handshake aborts everything immediately with no event emitted.

Test Plan:
- Defaults, MODE 0, channel 0 driven 0→1 before edge k and held → change[0] pulses after edge k+5, stable_value ch0=1, evt_valid high after edge k+6 with evt_channel=0, evt_value=1; evt_ready=1 clears it.
- Glitch: ch1 driven 0→3 for 3 cycles, then back to 0 → no change, no event, stable_value ch1 stays 0.
- Channels 0, 2 and 3 change on the same cycle, evt_ready=1 → three consecutive events in order 0, 2, 3, each with its correct value, then evt_valid=0.
- evt_ready=0; ch2 accepts 1, then 2 → first event shows value 1 and holds; overrun[2]=1; after ready, a second event for ch2 with value 2.
- MODE 1, PERIOD_COUNT=1, ch0 sequence 1, 2, 3, each held 2 cycles → change[0] toggles three times, ending at 1.
- Assert reset=0 while ch0 is mid-count at cnt=3 and an event is pending → all outputs 0 immediately; after release with input stable at 0, no event appears.
